// File: rtl/seg_mux_driver_if.sv
// Bus between the digit-select source / hex data producer and seg_mux_driver.
// Carries the select and load controls, the two hex digits, and the LED drive outputs.
interface seg_mux_driver_if;
   logic       sel;
   logic       load;
   logic [3:0] digit0;
   logic [3:0] digit1;
   logic [6:0] seg;
   logic       an0;
   logic       an1;
   logic       active_digit;

   modport master (
      output sel, load, digit0, digit1,
      input  seg, an0, an1, active_digit
   );

   modport slave (
      input  sel, load, digit0, digit1,
      output seg, an0, an1, active_digit
   );
endinterface

// File: rtl/seg_mux_driver.sv
// seg_mux_driver: dual seven-segment multiplexer with dead-time blanking.
// Every change of sel blanks both digits for BLANK_CYCLES clocks and commits the
// pending digits into the display registers. A lit digit's value therefore never
// changes while it is lit.
// Optional macro LEADING_ZERO_BLANK_EN: keeps the left digit dark when it holds 0.
module seg_mux_driver #(
   parameter int unsigned BLANK_CYCLES = 64
) (
   input  logic            clk,
   input  logic            reset,
   seg_mux_driver_if.slave bus
);
   typedef enum logic [1:0] {BLANK, SHOW0, SHOW1} state_t;

   localparam logic [15:0] CNT_INIT = 16'(BLANK_CYCLES - 1);
   localparam logic [6:0]  SEG_OFF  = 7'h7F;

   state_t          state_q, state_d;
   logic [15:0]     count_q, count_d;
   logic            target_q, target_d;
   logic            sel_q;
   logic [1:0][3:0] pend_q, pend_d;
   logic [1:0][3:0] disp_q, disp_d;
   logic [6:0]      seg_q, seg_d;
   logic            an0_q, an0_d;
   logic            an1_q, an1_d;
   logic            act_q, act_d;
   logic            change;

   // Active-low segment decode, seg = {g,f,e,d,c,b,a}.
   function automatic logic [6:0] decode(input logic [3:0] h);
      case (h)
         4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
         4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
         4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
         4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
         4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
         4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
         4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
         4'hE: decode = 7'h06;  default: decode = 7'h0E;
      endcase
   endfunction

   assign change           = (bus.sel != sel_q);
   assign bus.seg          = seg_q;
   assign bus.an0          = an0_q;
   assign bus.an1          = an1_q;
   assign bus.active_digit = act_q;

   // Next-state logic: a select change always wins and restarts blanking.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      target_d = target_q;
      disp_d   = disp_q;
      seg_d    = seg_q;
      an0_d    = an0_q;
      an1_d    = an1_q;
      act_d    = act_q;
      pend_d   = bus.load ? {bus.digit1, bus.digit0} : pend_q;

      if (change) begin
         state_d  = BLANK;
         count_d  = CNT_INIT;
         target_d = bus.sel;
         disp_d   = pend_q;     // commit the pre-load values
         seg_d    = SEG_OFF;
         an0_d    = 1'b1;
         an1_d    = 1'b1;
      end else begin
         case (state_q)
            BLANK: begin
               if (count_q != 16'd0) begin
                  count_d = count_q - 16'd1;
               end else begin
                  act_d = target_q;
                  if (target_q) begin
                     state_d = SHOW1;
                     an0_d   = 1'b1;
                     an1_d   = 1'b0;
                     seg_d   = decode(disp_q[1]);
`ifdef LEADING_ZERO_BLANK_EN
                     if (disp_q[1] == 4'h0) begin
                        an1_d = 1'b1;
                        seg_d = SEG_OFF;
                     end
`endif
                  end else begin
                     state_d = SHOW0;
                     an0_d   = 1'b0;
                     an1_d   = 1'b1;
                     seg_d   = decode(disp_q[0]);
                  end
               end
            end
            default: ;          // SHOW0/SHOW1 hold outputs
         endcase
      end
   end

   // State and output registers; reset starts a blanking period toward the current sel.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= BLANK;
         count_q  <= CNT_INIT;
         target_q <= bus.sel;
         sel_q    <= bus.sel;
         pend_q   <= '0;
         disp_q   <= '0;
         seg_q    <= SEG_OFF;
         an0_q    <= 1'b1;
         an1_q    <= 1'b1;
         act_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         target_q <= target_d;
         sel_q    <= bus.sel;
         pend_q   <= pend_d;
         disp_q   <= disp_d;
         seg_q    <= seg_d;
         an0_q    <= an0_d;
         an1_q    <= an1_d;
         act_q    <= act_d;
      end
   end
endmodule

// File: tb/tb_seg_mux_driver.sv
// Bench for seg_mux_driver with BLANK_CYCLES = 4: directed vector table,
// a decode sweep, and random stimulus against a timeline-based reference model.
module tb_seg_mux_driver;
   localparam int BC = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   seg_mux_driver_if bif ();
   seg_mux_driver #(.BLANK_CYCLES(BC)) dut (.clk(clk), .reset(reset), .bus(bif));

   typedef struct {
      bit         rst, sel, ld;
      logic [3:0] d0, d1;
      logic [6:0] seg;
      bit         an0, an1, act;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_err = 0;

   logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   // Reference model: cycles since the last change (or reset), and digit registers.
   int         since;
   bit         m_sel, m_tgt, m_act;
   logic [3:0] m_pend [2];
   logic [3:0] m_disp [2];

   function automatic void addn(int n, bit rst, bit s, bit ld, logic [3:0] d0, logic [3:0] d1,
                                logic [6:0] sg, bit a0, bit a1, bit act);
      vec_t v;
      v.rst = rst; v.sel = s; v.ld = ld; v.d0 = d0; v.d1 = d1;
      v.seg = sg; v.an0 = a0; v.an1 = a1; v.act = act;
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endfunction

   task automatic check(string name, logic [9:0] got, logic [9:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got seg/an0/an1/act=%h/%b/%b/%b required %h/%b/%b/%b", name,
                  got[9:3], got[2], got[1], got[0], exp[9:3], exp[2], exp[1], exp[0]);
      end
   endtask

   // Drive one cycle of inputs, advance the model, clock, then compare to the model.
   task automatic step(bit rst, bit s, bit ld, logic [3:0] d0, logic [3:0] d1);
      logic [9:0] exp;
      reset = rst; bif.sel = s; bif.load = ld; bif.digit0 = d0; bif.digit1 = d1;
      if (rst) begin
         m_pend = '{4'h0, 4'h0}; m_disp = '{4'h0, 4'h0};
         m_sel = s; m_tgt = s; m_act = 1'b0; since = 0;
      end else begin
         if (s != m_sel) begin
            m_disp = m_pend; m_tgt = s; since = 0;
         end else if (since < BC) begin
            since++;
         end
         m_sel = s;
         if (ld) begin m_pend[0] = d0; m_pend[1] = d1; end
      end
      if (since >= BC) begin
         m_act = m_tgt;
         if (m_tgt) exp = {dec[m_disp[1]], 1'b1, 1'b0, 1'b1};
         else       exp = {dec[m_disp[0]], 1'b0, 1'b1, 1'b0};
         if (LZ && m_tgt && m_disp[1] == 4'h0) exp = {7'h7F, 1'b1, 1'b1, 1'b1};
      end else begin
         exp = {7'h7F, 1'b1, 1'b1, m_act};
      end
      @(posedge clk); #1;
      check("model", {bif.seg, bif.an0, bif.an1, bif.active_digit}, exp);
   endtask

   initial begin
      reset = 1'b1; bif.sel = 1'b0; bif.load = 1'b0; bif.digit0 = '0; bif.digit1 = '0;
      since = 0; m_sel = 0; m_tgt = 0; m_act = 0;
      m_pend = '{4'h0, 4'h0}; m_disp = '{4'h0, 4'h0};

      // Reset, then first show of digit0 = 0
      addn(1, 1, 0, 0, 0, 0, 7'h7F, 1, 1, 0);
      addn(3, 0, 0, 0, 0, 0, 7'h7F, 1, 1, 0);
      addn(1, 0, 0, 0, 0, 0, 7'h40, 0, 1, 0);
      // Load 3/A, toggle to digit1, back to digit0
      addn(1, 0, 0, 1, 4'h3, 4'hA, 7'h40, 0, 1, 0);
      addn(4, 0, 1, 0, 0, 0, 7'h7F, 1, 1, 0);
      addn(1, 0, 1, 0, 0, 0, 7'h08, 1, 0, 1);
      addn(4, 0, 0, 0, 0, 0, 7'h7F, 1, 1, 1);
      addn(1, 0, 0, 0, 0, 0, 7'h30, 0, 1, 0);
      // Double toggle inside blanking restarts dead time
      addn(1, 0, 1, 0, 0, 0, 7'h7F, 1, 1, 0);
      addn(4, 0, 0, 0, 0, 0, 7'h7F, 1, 1, 0);
      addn(1, 0, 0, 0, 0, 0, 7'h30, 0, 1, 0);
      // Load during SHOW0 does not disturb the lit digit
      addn(1, 0, 0, 1, 4'h5, 4'hA, 7'h30, 0, 1, 0);
      addn(2, 0, 0, 0, 0, 0, 7'h30, 0, 1, 0);
      // Load on a change edge: the commit uses the older pending {A,5}
      addn(1, 0, 1, 1, 4'h7, 4'h1, 7'h7F, 1, 1, 0);
      addn(3, 0, 1, 0, 0, 0, 7'h7F, 1, 1, 0);
      addn(1, 0, 1, 0, 0, 0, 7'h08, 1, 0, 1);
      addn(4, 0, 0, 0, 0, 0, 7'h7F, 1, 1, 1);
      addn(1, 0, 0, 0, 0, 0, 7'h78, 0, 1, 0);
      // Into SHOW1 with digit1 = 1, then reset mid-show
      addn(4, 0, 1, 0, 0, 0, 7'h7F, 1, 1, 0);
      addn(1, 0, 1, 0, 0, 0, 7'h79, 1, 0, 1);
      addn(1, 1, 1, 0, 0, 0, 7'h7F, 1, 1, 0);
      addn(3, 0, 1, 0, 0, 0, 7'h7F, 1, 1, 0);
      if (LZ) addn(1, 0, 1, 0, 0, 0, 7'h7F, 1, 1, 1);
      else    addn(1, 0, 1, 0, 0, 0, 7'h40, 1, 0, 1);

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].sel, tbl[i].ld, tbl[i].d0, tbl[i].d1);
         check($sformatf("table[%0d]", i), {bif.seg, bif.an0, bif.an1, bif.active_digit},
               {tbl[i].seg, tbl[i].an0, tbl[i].an1, tbl[i].act});
      end

      // Decode sweep of digit0 over 0..F
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < BC; i++) step(0, 0, 0, 0, 0);
      for (int v = 0; v < 16; v++) begin
         step(0, 0, 1, 4'(v), 4'h9);
         step(0, 1, 0, 0, 0);
         step(0, 0, 0, 0, 0);
         for (int i = 0; i < BC; i++) step(0, 0, 0, 0, 0);
         check($sformatf("sweep[%0h]", v), {bif.seg, bif.an0, bif.an1, bif.active_digit},
               {dec[v], 1'b0, 1'b1, 1'b0});
      end

      // Random traffic against the model
      begin
         bit s;
         s = 1'b0;
         for (int i = 0; i < 600; i++) begin
            bit r;
            r = ($urandom_range(99) == 0);
            if ($urandom_range(5) == 0) s = ~s;
            step(r, s, $urandom_range(3) == 0, 4'($urandom), 4'($urandom));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
